// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types for the dcache snoop responder: FSM states, snooped address layout and array geometry.
// The optional LL/SC link-register hook is enabled with SNOOP_LINKREG_EN.
package dcache_snoop_responder_pkg;

    localparam int SETS  = 8;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SEND0,
        SEND1,
        INVWAIT,
        DONE
    } snoop_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic             blkoff;
        logic [1:0]       bytoff;
    } snp_addr_t;

    // Two byte addresses fall in the same 2-word block when everything above the block offset agrees.
    function automatic logic same_block(input logic [31:0] a, input logic [31:0] b);
        return a[31:3] == b[31:3];
    endfunction

endpackage

// File: rtl/dcache_snoop_responder_tag_match.sv
// Combinational 2-way tag compare for the snoop port: hit, hit way (way 0 wins ties) and M-state of the hit.
module snoop_tag_match
    import dcache_snoop_responder_pkg::*;
(
    input  logic [TAG_W-1:0]      tag,
    input  logic [1:0][TAG_W-1:0] arr_tag,
    input  logic [1:0]            arr_valid,
    input  logic [1:0]            arr_dirty,
    output logic                  hit,
    output logic                  way,
    output logic                  m_hit
);

    logic [1:0] way_match;

    always_comb begin
        way_match[0] = arr_valid[0] && (arr_tag[0] == tag);
        way_match[1] = arr_valid[1] && (arr_tag[1] == tag);
        hit          = |way_match;
        way          = !way_match[0] && way_match[1];
        m_hit        = hit && arr_dirty[way];
    end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Snoop responder for one dcache: looks up snooped addresses, sources M blocks cache-to-cache and downgrades/invalidates frames.
// Define SNOOP_LINKREG_EN to add the link-register clear output used to break LL/SC on remote writes.
module dcache_snoop_responder
    import dcache_snoop_responder_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        ccwait,
    input  logic                        ccinv,
    input  logic [31:0]                 ccsnoopaddr,
    input  logic                        dwait,
    input  logic [1:0][TAG_W-1:0]       arr_tag,
    input  logic [1:0]                  arr_valid,
    input  logic [1:0]                  arr_dirty,
    input  logic [1:0][1:0][31:0]       arr_data,
`ifdef SNOOP_LINKREG_EN
    input  logic                        link_valid,
    input  logic [31:0]                 link_addr,
    output logic                        link_clr,
`endif
    output logic [IDX_W-1:0]            snp_idx,
    output logic                        ccwrite,
    output logic [31:0]                 dstore,
    output logic                        upd_en,
    output logic                        upd_way,
    output logic                        upd_valid,
    output logic                        upd_dirty,
    output logic                        snp_busy
);

    snoop_state_t     state, next_state;
    snp_addr_t        cur_addr;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_hit, lat_way, lat_mhit;
    logic             inv_seen;
    logic             ccwrite_q, ccwrite_d;
    logic             upd_en_raw;
    logic             match_hit, match_way, match_mhit;
    logic             unused_offset_bits;

    assign cur_addr           = ccsnoopaddr;
    assign unused_offset_bits = ^{cur_addr.blkoff, cur_addr.bytoff};

    snoop_tag_match u_tag_match (
        .tag       (cur_addr.tag),
        .arr_tag   (arr_tag),
        .arr_valid (arr_valid),
        .arr_dirty (arr_dirty),
        .hit       (match_hit),
        .way       (match_way),
        .m_hit     (match_mhit)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Lookup results are captured on the request cycle so the arrays can be re-indexed by the latched set.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            lat_idx   <= '0;
            lat_hit   <= 1'b0;
            lat_way   <= 1'b0;
            lat_mhit  <= 1'b0;
            inv_seen  <= 1'b0;
            ccwrite_q <= 1'b0;
        end else begin
            ccwrite_q <= ccwrite_d;
            if (state == IDLE && ccwait) begin
                lat_idx  <= cur_addr.idx;
                lat_hit  <= match_hit;
                lat_way  <= match_way;
                lat_mhit <= match_mhit;
            end
            if (next_state == IDLE) begin
                inv_seen <= 1'b0;
            end else if (state != IDLE) begin
                inv_seen <= inv_seen | ccinv;
            end
        end
    end

    always_comb begin
        next_state = state;
        ccwrite_d  = 1'b0;
        upd_en_raw = 1'b0;
        upd_way    = 1'b0;
        upd_valid  = 1'b0;
        upd_dirty  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ccwait) begin
                    next_state = LOOKUP;
                    ccwrite_d  = match_mhit;
                end else if (ccinv && match_hit) begin
                    upd_en_raw = 1'b1;
                    upd_way    = match_way;
                end
            end
            LOOKUP: begin
                if (lat_mhit) begin
                    next_state = SEND0;
                    ccwrite_d  = 1'b1;
                end else begin
                    next_state = INVWAIT;
                end
            end
            SEND0: begin
                ccwrite_d = 1'b1;
                if (!dwait) begin
                    next_state = SEND1;
                end
            end
            SEND1: begin
                if (!dwait) begin
                    next_state = DONE;
                end else begin
                    ccwrite_d = 1'b1;
                end
            end
            INVWAIT: begin
                if (!ccwait) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                upd_way    = lat_way;
                if (lat_hit) begin
                    if (inv_seen || ccinv) begin
                        upd_en_raw = 1'b1;
                    end else if (lat_mhit) begin
                        upd_en_raw = 1'b1;
                        upd_valid  = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dstore = '0;
        if (state == SEND0) begin
            dstore = arr_data[lat_way][0];
        end else if (state == SEND1) begin
            dstore = arr_data[lat_way][1];
        end
    end

    // A reset cycle must never write the arrays, even though the write strobe is combinational.
    assign upd_en   = upd_en_raw && nRST;
    assign ccwrite  = ccwrite_q;
    assign snp_idx  = (state == IDLE) ? cur_addr.idx : lat_idx;
    assign snp_busy = (state != IDLE) || ccwait || ccinv;

`ifdef SNOOP_LINKREG_EN
    logic [31:0] lat_addr;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            lat_addr <= '0;
        end else if (state == IDLE && ccwait) begin
            lat_addr <= ccsnoopaddr;
        end
    end

    assign link_clr = upd_en && !upd_valid && link_valid &&
                      same_block((state == IDLE) ? ccsnoopaddr : lat_addr, link_addr);
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Directed testbench for dcache_snoop_responder: IDLE lookup vector table plus hand-built snoop transactions.
module tb_dcache_snoop_responder;
    import dcache_snoop_responder_pkg::*;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  ccwait, ccinv, dwait;
    logic [31:0]           ccsnoopaddr;
    logic [1:0][TAG_W-1:0] arr_tag;
    logic [1:0]            arr_valid, arr_dirty;
    logic [1:0][1:0][31:0] arr_data;
    logic [IDX_W-1:0]      snp_idx;
    logic                  ccwrite, upd_en, upd_way, upd_valid, upd_dirty, snp_busy;
    logic [31:0]           dstore;
`ifdef SNOOP_LINKREG_EN
    logic                  link_valid = 1'b0;
    logic [31:0]           link_addr  = '0;
    logic                  link_clr;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [31:0] ADDR_A = 32'h0000_2A58;
    localparam logic [31:0] ADDR_B = 32'h0000_1040;

    always #5 CLK = ~CLK;

    dcache_snoop_responder dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .dwait       (dwait),
        .arr_tag     (arr_tag),
        .arr_valid   (arr_valid),
        .arr_dirty   (arr_dirty),
        .arr_data    (arr_data),
`ifdef SNOOP_LINKREG_EN
        .link_valid  (link_valid),
        .link_addr   (link_addr),
        .link_clr    (link_clr),
`endif
        .snp_idx     (snp_idx),
        .ccwrite     (ccwrite),
        .dstore      (dstore),
        .upd_en      (upd_en),
        .upd_way     (upd_way),
        .upd_valid   (upd_valid),
        .upd_dirty   (upd_dirty),
        .snp_busy    (snp_busy)
    );

    typedef struct {
        logic [31:0]      addr;
        logic             inv;
        logic [TAG_W-1:0] tag0;
        logic [TAG_W-1:0] tag1;
        logic [1:0]       valid;
        logic [1:0]       dirty;
        logic [2:0]       exp_idx;
        logic             exp_upd_en;
        logic             exp_upd_way;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for the next falling edge, drives the request inputs, then lets the combinational outputs settle.
    task automatic apply_stimulus(input logic w, input logic inv, input logic dw);
        @(negedge CLK);
        ccwait = w;
        ccinv  = inv;
        dwait  = dw;
        #1;
    endtask

    task automatic set_ways(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                            input logic [1:0] v, input logic [1:0] d);
        arr_tag[0] = t0;
        arr_tag[1] = t1;
        arr_valid  = v;
        arr_dirty  = d;
    endtask

    initial begin
        nRST        = 1'b0;
        ccwait      = 1'b0;
        ccinv       = 1'b0;
        dwait       = 1'b0;
        ccsnoopaddr = '0;
        set_ways('0, '0, 2'b00, 2'b00);
        arr_data[0][0] = 32'hA0A0_0000;
        arr_data[0][1] = 32'hA0A0_0001;
        arr_data[1][0] = 32'hB1B1_0000;
        arr_data[1][1] = 32'hB1B1_0001;

        vecs[0] = '{32'h0000_1040, 1'b1, 26'h99, 26'h41, 2'b11, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'h0000_1040, 1'b1, 26'h41, 26'h41, 2'b11, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_1040, 1'b1, 26'h41, 26'h41, 2'b10, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_1040, 1'b1, 26'h41, 26'h41, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_2A58, 1'b0, 26'hA9, 26'h00, 2'b01, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_2A58, 1'b1, 26'hA9, 26'h12, 2'b11, 2'b01, 3'd3, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_003F, 1'b1, 26'h00, 26'h01, 2'b00, 2'b00, 3'd7, 1'b0, 1'b0, 1'b1};

        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("reset_ccwrite", ccwrite, 0);
        check_output("reset_dstore", dstore, 0);
        check_output("reset_upd_en", upd_en, 0);
        check_output("reset_busy", snp_busy, 0);
        nRST = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            ccsnoopaddr = vecs[i].addr;
            ccinv       = vecs[i].inv;
            ccwait      = 1'b0;
            set_ways(vecs[i].tag0, vecs[i].tag1, vecs[i].valid, vecs[i].dirty);
            #1;
            check_output($sformatf("vec%0d_idx", i), snp_idx, vecs[i].exp_idx);
            check_output($sformatf("vec%0d_upd_en", i), upd_en, vecs[i].exp_upd_en);
            check_output($sformatf("vec%0d_busy", i), snp_busy, vecs[i].exp_busy);
            if (vecs[i].exp_upd_en) begin
                check_output($sformatf("vec%0d_upd_way", i), upd_way, vecs[i].exp_upd_way);
                check_output($sformatf("vec%0d_upd_valid", i), upd_valid, 0);
            end
        end

        // Way 1 in M: block sourced, then downgraded to S.
        ccsnoopaddr = ADDR_A;
        set_ways(26'h55, 26'hA9, 2'b11, 2'b10);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t1_idle_ccwrite", ccwrite, 0);
        check_output("t1_idle_idx", snp_idx, 3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t1_lookup_ccwrite", ccwrite, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t1_send0_dstore", dstore, 32'hB1B1_0000);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t1_send1_dstore", dstore, 32'hB1B1_0001);
        check_output("t1_send1_ccwrite", ccwrite, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t1_done_upd_en", upd_en, 1);
        check_output("t1_done_upd_way", upd_way, 1);
        check_output("t1_done_upd_valid", upd_valid, 1);
        check_output("t1_done_upd_dirty", upd_dirty, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t1_idle_upd_en", upd_en, 0);
        check_output("t1_idle_ccwrite_low", ccwrite, 0);
        check_output("t1_idle_busy", snp_busy, 0);

        // Same M hit with ccinv arriving during SEND1: frame is invalidated instead.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t2_send0_dstore", dstore, 32'hB1B1_0000);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("t2_send1_dstore", dstore, 32'hB1B1_0001);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t2_done_upd_en", upd_en, 1);
        check_output("t2_done_upd_way", upd_way, 1);
        check_output("t2_done_upd_valid", upd_valid, 0);
        check_output("t2_done_upd_dirty", upd_dirty, 0);

        // Way 0 in S: no data sourced, invalidated in DONE.
        set_ways(26'hA9, 26'h77, 2'b11, 2'b00);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t3_lookup_ccwrite", ccwrite, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t3_invwait_ccwrite", ccwrite, 0);
        check_output("t3_invwait_upd_en", upd_en, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t3_done_upd_en", upd_en, 1);
        check_output("t3_done_upd_way", upd_way, 0);
        check_output("t3_done_upd_valid", upd_valid, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t3_idle_busy", snp_busy, 0);

        // Miss: walks through INVWAIT/DONE without touching the arrays.
        set_ways(26'h11, 26'h22, 2'b11, 2'b11);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t4_lookup_ccwrite", ccwrite, 0);
        check_output("t4_lookup_busy", snp_busy, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t4_done_upd_en", upd_en, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t4_idle_busy", snp_busy, 0);
        check_output("t4_idle_upd_en", upd_en, 0);

        // ccinv alone in IDLE on an S hit at 0x1040 (set 0, tag 0x41 in way 1).
        ccsnoopaddr = ADDR_B;
        set_ways(26'h40, 26'h41, 2'b11, 2'b00);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t5_upd_en", upd_en, 1);
        check_output("t5_upd_way", upd_way, 1);
        check_output("t5_upd_valid", upd_valid, 0);
        check_output("t5_idx", snp_idx, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t5_after_upd_en", upd_en, 0);

        // Way 0 in M with RAM stalling SEND0, then reset while in SEND1.
        ccsnoopaddr = ADDR_A;
        set_ways(26'hA9, 26'h33, 2'b11, 2'b01);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("t6_lookup_ccwrite", ccwrite, 1);
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1);
            check_output($sformatf("t6_stall%0d_dstore", c), dstore, 32'hA0A0_0000);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t6_accept_dstore", dstore, 32'hA0A0_0000);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t6_send1_dstore", dstore, 32'hA0A0_0001);
        nRST = 1'b0;
        #1;
        check_output("t6_reset_upd_en", upd_en, 0);
        @(negedge CLK);
        nRST   = 1'b1;
        ccwait = 1'b0;
        ccinv  = 1'b0;
        #1;
        check_output("t6_after_reset_ccwrite", ccwrite, 0);
        check_output("t6_after_reset_upd_en", upd_en, 0);
        check_output("t6_after_reset_busy", snp_busy, 0);
        check_output("t6_after_reset_dstore", dstore, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t6_idle_upd_en", upd_en, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
